acc_dump_arbiter: RTL and testbench
===================================

ACC_DUMP_ARBITER -- requirements
Module: acc_dump_arbiter

Interface
REQ-001 Parameter: TCQ, 0.1, simulation clock-to-Q delay on all registered assignments; no functional effect.
REQ-002 clk_i  in  1  single clock; all logic in this domain.
REQ-003 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 pmt_scan_en_i  in  1  scan enable; low = flush/ignore.
REQ-005 ch0_latch_en_i  in  1  one-cycle record strobe, channel 0.
REQ-006 ch0_latch_i  in  256  record, channel 0; valid only with strobe.
REQ-007 ch1_latch_en_i  in  1  one-cycle record strobe, channel 1.
REQ-008 ch1_latch_i  in  256  record, channel 1; valid only with strobe.
REQ-009 dump_data_o  out  32  serialized record word.
REQ-010 dump_vld_o  out  1  word valid.
REQ-011 dump_rdy_i  in  1  downstream ready; transfer = dump_vld_o && dump_rdy_i.
REQ-012 dump_last_o  out  1  high on word 7 of a record.
REQ-013 dump_ch_o  out  1  source channel of the record being sent.
REQ-014 drop_cnt0_o / drop_cnt1_o  out  16 each  dropped-record counts per channel.
REQ-015 busy_o  out  1  high when FSM in SEND or any pending flag set.

Function
REQ-016 Each channel SHALL own a 1-deep holding register (256b) plus pending flag.
REQ-017 Strobe with pmt_scan_en_i=1 and (pending=0 or channel granted this cycle) SHALL capture the record and set pending next cycle.
REQ-018 Strobe with pmt_scan_en_i=1, pending=1, not granted this cycle SHALL discard the new record, keep the held one, and increment that channel's drop counter, saturating at 0xFFFF.
REQ-019 FSM states: IDLE, SEND; reset state IDLE.
REQ-020 IDLE: if any pending, grant one channel, copy its holding register to the 256b shift register, clear its pending, set word index 0, go to SEND; else stay.
REQ-021 Grant SHALL be round-robin: sole pending channel wins; if both pending, channel != last_grant wins; last_grant updates on every grant.
REQ-022 SEND: dump_vld_o=1, dump_data_o = shift[32*idx+31 : 32*idx] (word 0 = bits 31:0, little-endian), dump_ch_o = granted channel.
REQ-023 On transfer in SEND: idx<7 -> idx+1; idx=7 -> return to IDLE (one idle cycle between records).
REQ-024 dump_data_o, dump_last_o, dump_ch_o SHALL remain stable while dump_vld_o=1 and dump_rdy_i=0.
REQ-025 dump_vld_o SHALL be 0 in IDLE; dump_last_o = (SEND && idx==7).
REQ-026 Latency: strobe at cycle N, FSM idle, other channel not pending -> pending at N+1, dump_vld_o with word 0 at N+2.
REQ-027 Throughput with rdy=1: one record per 9 cycles.
REQ-028 pmt_scan_en_i=0: pending flags cleared, strobes ignored and not counted; a record already in SEND SHALL complete all 8 words.
REQ-029 Rising edge of pmt_scan_en_i SHALL clear both drop counters and set last_grant=1.
REQ-030 Simultaneous strobes on both channels SHALL both be captured if both holding registers free.

Reset
REQ-031 rst_n_i low SHALL immediately force: FSM IDLE, idx 0, pending 0, shift/holding 0, last_grant 1, drop counters 0, dump_vld_o 0, dump_last_o 0, dump_ch_o 0, dump_data_o 0, busy_o 0.
REQ-032 Reset assertion mid-SEND SHALL abort the record; no words resume after release.
REQ-033 Reset release SHALL be synchronized internally; first capture possible on the 2nd clk_i edge after release.

Verification
REQ-034 Single record: ch0 strobe, data word k = 0x1000_0000+k, rdy=1 -> 8 transfers at N+2..N+9, words 0x10000000..0x10000007, last on 8th, dump_ch_o=0.
REQ-035 Backpressure: rdy toggled 1/0 each cycle -> all 8 words emitted in order, outputs stable during rdy=0, no duplicates or losses.
REQ-036 Simultaneous strobes after reset -> ch0 record sent first, then ch1; next double strobe after both -> ch0 first again (last_grant=1 rule).
REQ-037 Overflow: 3 ch1 strobes within 4 cycles, rdy=0 -> first sent, second held, third dropped, drop_cnt1_o=1; 70000 overflows -> saturates at 0xFFFF.
REQ-038 pmt_scan_en_i deasserted at word 3 with ch0 pending -> current record finishes 8 words, pending ch0 never sent, later strobes ignored; re-enable -> drop counters 0.
REQ-039 rst_n_i pulsed low at word 4 -> dump_vld_o 0 asynchronously, all outputs at reset values, no residual words after release.

Source files
------------

// File: rtl/acc_dump_arbiter.sv
// acc_dump_arbiter
//   Two record channels, each with a 1-deep 256-bit holding register, share
//   one 32-bit dump port. A two-state FSM (IDLE/SEND) grants a pending channel
//   round-robin, copies its record into a shift register and emits eight
//   little-endian 32-bit words with valid/ready handshaking.
//
// Ports
//   clk_i, rst_n_i         clock; asynchronous active-low reset
//   pmt_scan_en_i          scan enable; low flushes pending records
//   ch0_latch_en_i/_i      channel 0 record strobe and 256-bit record
//   ch1_latch_en_i/_i      channel 1 record strobe and 256-bit record
//   dump_data_o            current word of the record being sent
//   dump_vld_o/dump_rdy_i  handshake; a word moves when both are high
//   dump_last_o            marks word 7
//   dump_ch_o              source channel of the record being sent
//   drop_cnt0_o/1_o        saturating per-channel dropped-record counts
//   busy_o                 sending, or a record is waiting
module acc_dump_arbiter #(
   parameter real TCQ = 0.1
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         pmt_scan_en_i,
   input  logic         ch0_latch_en_i,
   input  logic [255:0] ch0_latch_i,
   input  logic         ch1_latch_en_i,
   input  logic [255:0] ch1_latch_i,
   output logic [31:0]  dump_data_o,
   output logic         dump_vld_o,
   input  logic         dump_rdy_i,
   output logic         dump_last_o,
   output logic         dump_ch_o,
   output logic [15:0]  drop_cnt0_o,
   output logic [15:0]  drop_cnt1_o,
   output logic         busy_o
);

   localparam int NUM_CH = 2;
   localparam int REC_W  = 256;
   localparam int WORD_W = 32;
   localparam int CNT_W  = 16;
   localparam int IDX_W  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // TCQ only shapes simulation timing in the reference model; the RTL keeps
   // zero-delay assignments. A negative value is meaningless.
   if (TCQ < 0.0) begin : g_tcq_neg
   end

   // Reset asserts asynchronously and releases on the first clock edge after
   // rst_n_i rises, so the first record can be captured on the second edge.
   logic rst_sync_n;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rst_sync_n <= 1'b0;
      else          rst_sync_n <= 1'b1;
   end

   state_t                          state_q, state_d;
   logic [IDX_W-1:0]                idx_q;
   logic [REC_W-1:0]                shift_q;
   logic                            ch_q;
   logic                            last_grant_q;
   logic                            scan_q;
   logic                            scan_rise;

   logic [NUM_CH-1:0]               strobe;
   logic [NUM_CH-1:0][REC_W-1:0]    rec;
   logic [NUM_CH-1:0]               pending;
   logic [NUM_CH-1:0][REC_W-1:0]    hold;
   logic [NUM_CH-1:0][CNT_W-1:0]    drop_cnt;
   logic [NUM_CH-1:0]               grant;
   logic                            grant_vld;
   logic                            grant_ch;

   assign strobe = {ch1_latch_en_i, ch0_latch_en_i};
   assign rec    = {ch1_latch_i, ch0_latch_i};

   always_ff @(posedge clk_i or negedge rst_sync_n) begin
      if (!rst_sync_n) scan_q <= 1'b0;
      else             scan_q <= pmt_scan_en_i;
   end

   assign scan_rise = pmt_scan_en_i & ~scan_q;

   // Per-channel holding register, pending flag and drop counter. A channel
   // granted this cycle frees its slot in the same edge, so a strobe arriving
   // alongside the grant is kept rather than dropped.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic             take;
      logic             drop;
      logic             pend_q;
      logic [REC_W-1:0] hold_q;
      logic [CNT_W-1:0] cnt_q;

      assign take = pmt_scan_en_i & strobe[c] & (~pend_q | grant[c]);
      assign drop = pmt_scan_en_i & strobe[c] & pend_q & ~grant[c];

      always_ff @(posedge clk_i or negedge rst_sync_n) begin
         if (!rst_sync_n) begin
            pend_q <= 1'b0;
            hold_q <= '0;
            cnt_q  <= '0;
         end else begin
            if (!pmt_scan_en_i) begin
               pend_q <= 1'b0;
            end else if (take) begin
               pend_q <= 1'b1;
               hold_q <= rec[c];
            end else if (grant[c]) begin
               pend_q <= 1'b0;
            end

            if (scan_rise)                  cnt_q <= '0;
            else if (drop && cnt_q != '1)   cnt_q <= cnt_q + CNT_W'(1);
         end
      end

      assign pending[c]  = pend_q;
      assign hold[c]     = hold_q;
      assign drop_cnt[c] = cnt_q;
   end

   // Arbitration plus FSM next-state and outputs. Grants are suppressed while
   // scanning is disabled since those records are being flushed anyway.
   always_comb begin
      grant_vld   = (state_q == IDLE) & pmt_scan_en_i & (|pending);
      grant_ch    = (&pending) ? ~last_grant_q : pending[1];
      grant       = '0;
      state_d     = state_q;
      dump_vld_o  = 1'b0;
      dump_last_o = 1'b0;
      dump_data_o = '0;

      if (grant_vld) grant[grant_ch] = 1'b1;

      case (state_q)
         IDLE: begin
            if (grant_vld) state_d = SEND;
         end
         SEND: begin
            dump_vld_o  = 1'b1;
            dump_data_o = shift_q[{idx_q, 5'd0} +: WORD_W];
            dump_last_o = (idx_q == 3'd7);
            if (dump_rdy_i && idx_q == 3'd7) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_sync_n) begin
      if (!rst_sync_n) state_q <= IDLE;
      else             state_q <= state_d;
   end

   // Record datapath. idx wraps 7 -> 0 on the last transfer, leaving it ready
   // for the next grant.
   always_ff @(posedge clk_i or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         shift_q      <= '0;
         idx_q        <= '0;
         ch_q         <= 1'b0;
         last_grant_q <= 1'b1;
      end else if (grant_vld) begin
         shift_q      <= hold[grant_ch];
         idx_q        <= '0;
         ch_q         <= grant_ch;
         last_grant_q <= grant_ch;
      end else begin
         if (state_q == SEND && dump_rdy_i) idx_q <= idx_q + IDX_W'(1);
         if (scan_rise)                     last_grant_q <= 1'b1;
      end
   end

   assign dump_ch_o   = ch_q;
   assign drop_cnt0_o = drop_cnt[0];
   assign drop_cnt1_o = drop_cnt[1];
   assign busy_o      = (state_q == SEND) | (|pending);

endmodule

// File: tb/tb_acc_dump_arbiter.sv
// Directed + randomized bench for acc_dump_arbiter. A transaction-level model
// (per-channel slots, a queue of words in flight, saturating drop counts) is
// advanced once per clock and compared against the DUT after every edge.
module tb_acc_dump_arbiter;

   logic         clk = 1'b0;
   logic         rst_n, scan, e0, e1, rdy;
   logic [255:0] d0, d1;
   logic [31:0]  dump_data;
   logic         dump_vld, dump_last, dump_ch, busy;
   logic [15:0]  drop0, drop1;

   always #5 clk = ~clk;

   acc_dump_arbiter dut (
      .clk_i(clk), .rst_n_i(rst_n), .pmt_scan_en_i(scan),
      .ch0_latch_en_i(e0), .ch0_latch_i(d0),
      .ch1_latch_en_i(e1), .ch1_latch_i(d1),
      .dump_data_o(dump_data), .dump_vld_o(dump_vld), .dump_rdy_i(rdy),
      .dump_last_o(dump_last), .dump_ch_o(dump_ch),
      .drop_cnt0_o(drop0), .drop_cnt1_o(drop1), .busy_o(busy)
   );

   typedef struct {
      int          cyc;
      logic [31:0] d;
      logic        l;
      logic        c;
   } xfer_t;

   xfer_t        log_q[$];
   int           n_chk = 0, n_err = 0, cyc = 0, n0;
   bit           chk_en = 1'b1;

   // reference model state
   bit           m_pend[2];
   logic [255:0] m_hold[2];
   logic [31:0]  m_q[$];
   bit           m_ch, m_lg, m_scan_q, m_skip;
   int           m_drop[2];

   logic [255:0] ra, rb, rc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rnd_rec();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [31:0] wd(input logic [255:0] r, input int k);
      return r[32*k +: 32];
   endfunction

   task automatic model_reset();
      m_pend[0] = 0; m_pend[1] = 0;
      m_hold[0] = '0; m_hold[1] = '0;
      m_q.delete();
      m_ch = 0; m_lg = 1; m_scan_q = 0; m_skip = 1;
      m_drop[0] = 0; m_drop[1] = 0;
   endtask

   // One clock edge of the spec's behaviour, using the inputs present at it.
   task automatic model_edge();
      bit           stb[2];
      logic [255:0] recs[2];
      int           g;
      if (!rst_n) begin model_reset(); return; end
      if (m_skip) begin m_skip = 0; return; end
      stb[0] = e0; stb[1] = e1; recs[0] = d0; recs[1] = d1;
      g = -1;
      if (m_q.size() != 0) begin
         if (rdy) void'(m_q.pop_front());
      end else if (scan && (m_pend[0] || m_pend[1])) begin
         g = (m_pend[0] && m_pend[1]) ? (m_lg ? 0 : 1) : (m_pend[1] ? 1 : 0);
         for (int k = 0; k < 8; k++) m_q.push_back(m_hold[g][32*k +: 32]);
         m_ch = (g == 1); m_lg = (g == 1); m_pend[g] = 0;
      end
      if (scan && !m_scan_q) begin
         m_drop[0] = 0; m_drop[1] = 0;
         if (g < 0) m_lg = 1;
      end
      for (int c = 0; c < 2; c++) begin
         if (!scan) m_pend[c] = 0;
         else if (stb[c]) begin
            if (!m_pend[c]) begin m_hold[c] = recs[c]; m_pend[c] = 1; end
            else if (m_drop[c] < 65535) m_drop[c]++;
         end
      end
      m_scan_q = scan;
   endtask

   task automatic compare();
      bit exp_vld;
      exp_vld = (m_q.size() != 0);
      chk("vld", 64'(dump_vld), 64'(exp_vld));
      if (exp_vld) begin
         chk("data", 64'(dump_data), 64'(m_q[0]));
         chk("last_ch", 64'({dump_last, dump_ch}), 64'({m_q.size() == 1, m_ch}));
      end
      chk("busy", 64'(busy), 64'(exp_vld || m_pend[0] || m_pend[1]));
      chk("drops", 64'({drop0, drop1}), 64'({m_drop[0][15:0], m_drop[1][15:0]}));
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         if (dump_vld && rdy) log_q.push_back('{cyc, dump_data, dump_last, dump_ch});
         @(posedge clk);
         model_edge();
         cyc++;
         #1;
         e0 = 0; e1 = 0;
         if (chk_en) compare();
      end
   endtask

   task automatic chk_rec(input string tag, input int base, input logic [255:0] r, input logic ch);
      for (int k = 0; k < 8; k++) begin
         if (base + k < log_q.size()) begin
            chk(tag, 64'(log_q[base+k].d), 64'(wd(r, k)));
            chk(tag, 64'({log_q[base+k].c, log_q[base+k].l}), 64'({ch, k == 7}));
         end else begin
            chk(tag, 64'(log_q.size()), 64'(base + k + 1));
         end
      end
   endtask

   task automatic chk_rst_outputs(input string tag);
      chk(tag, 64'(dump_data), 64'd0);
      chk(tag, 64'({dump_vld, dump_last, dump_ch, busy, drop0, drop1}), 64'd0);
   endtask

   initial begin
      rst_n = 1; scan = 1; e0 = 0; e1 = 0; rdy = 1; d0 = '0; d1 = '0;
      model_reset();

      // reset state
      #2 rst_n = 0;
      #1 chk_rst_outputs("reset_state");
      step(3);
      rst_n = 1;
      step(3);

      // single record, fixed pattern, latency N+2..N+9
      for (int k = 0; k < 8; k++) d0[32*k +: 32] = 32'h1000_0000 + k;
      ra = d0; log_q.delete(); n0 = cyc; e0 = 1;
      step(12);
      chk("single_cnt", 64'(log_q.size()), 64'd8);
      chk_rec("single_rec", 0, ra, 1'b0);
      for (int k = 0; k < 8 && k < log_q.size(); k++)
         chk("single_cyc", 64'(log_q[k].cyc), 64'(n0 + 2 + k));

      // backpressure: rdy toggles every cycle
      ra = rnd_rec(); d1 = ra; e1 = 1; log_q.delete();
      step(1);
      for (int i = 0; i < 30; i++) begin rdy = ~rdy; step(1); end
      rdy = 1; step(3);
      chk("bp_cnt", 64'(log_q.size()), 64'd8);
      chk_rec("bp_rec", 0, ra, 1'b1);

      // reset, then simultaneous strobes: the one on the first edge after
      // release is ignored, the one on the second edge is captured
      rst_n = 0; step(2); rst_n = 1;
      d0 = rnd_rec(); d1 = rnd_rec(); e0 = 1; e1 = 1;
      step(1);
      chk("sync_edge1_busy", 64'(busy), 64'd0);
      ra = rnd_rec(); rb = rnd_rec(); d0 = ra; d1 = rb; e0 = 1; e1 = 1;
      log_q.delete();
      step(1);
      chk("sync_edge2_busy", 64'(busy), 64'd1);
      step(20);
      chk("dual1_cnt", 64'(log_q.size()), 64'd16);
      chk_rec("dual1_ch0", 0, ra, 1'b0);
      chk_rec("dual1_ch1", 8, rb, 1'b1);
      ra = rnd_rec(); rb = rnd_rec(); d0 = ra; d1 = rb; e0 = 1; e1 = 1;
      log_q.delete();
      step(21);
      chk_rec("dual2_ch0", 0, ra, 1'b0);
      chk_rec("dual2_ch1", 8, rb, 1'b1);

      // overflow on ch1 with rdy low, then saturation
      rdy = 0; log_q.delete();
      ra = rnd_rec(); rb = rnd_rec(); rc = rnd_rec();
      d1 = ra; e1 = 1; step(2);
      d1 = rb; e1 = 1; step(1);
      d1 = rc; e1 = 1; step(2);
      chk("ovf_drop1", 64'(drop1), 64'd1);
      chk_en = 0;
      for (int i = 0; i < 65533; i++) begin d1 = rc; e1 = 1; step(1); end
      chk_en = 1;
      chk("ovf_fffe", 64'(drop1), 64'hFFFE);
      for (int i = 0; i < 5; i++) begin e1 = 1; step(1); end
      chk("ovf_sat", 64'(drop1), 64'hFFFF);
      chk("ovf_drop0", 64'(drop0), 64'd0);
      rdy = 1; step(25);
      chk("ovf_cnt", 64'(log_q.size()), 64'd16);
      chk_rec("ovf_first", 0, ra, 1'b1);
      chk_rec("ovf_second", 8, rb, 1'b1);

      // scan disable at word 3 with ch0 pending
      log_q.delete();
      ra = rnd_rec(); rb = rnd_rec();
      d0 = ra; e0 = 1; step(2);
      d0 = rb; e0 = 1; step(3);
      chk("scan_word3", 64'(dump_data), 64'(wd(ra, 3)));
      scan = 0;
      d1 = rnd_rec(); e1 = 1; step(1);
      e0 = 1; step(30);
      chk("scan_cnt", 64'(log_q.size()), 64'd8);
      chk_rec("scan_rec", 0, ra, 1'b0);
      chk("scan_idle", 64'({busy, dump_vld}), 64'd0);
      chk("scan_drops_kept", 64'({drop0, drop1}), 64'h0000_FFFF);
      scan = 1; step(1);
      chk("scan_reen_drops", 64'({drop0, drop1}), 64'd0);

      // reset pulse at word 4
      ra = rnd_rec(); d0 = ra; e0 = 1;
      step(6);
      chk("rst_word4", 64'(dump_data), 64'(wd(ra, 4)));
      #1 rst_n = 0;
      #1 chk_rst_outputs("rst_mid_send");
      log_q.delete();
      step(2);
      rst_n = 1;
      step(20);
      chk("rst_no_residual", 64'(log_q.size()), 64'd0);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         e0 = ($urandom_range(0, 4) == 0); d0 = rnd_rec();
         e1 = ($urandom_range(0, 4) == 0); d1 = rnd_rec();
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) scan = ~scan;
         step(1);
      end
      scan = 1; rdy = 1;
      step(25);
      chk("final_idle", 64'({busy, dump_vld}), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
